// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time,
// buffers the returned word and presents it to decode.
module fetch_unit #(
   parameter int                     PC_WIDTH  = 32,
   parameter logic [PC_WIDTH-1:0]    RESET_PC  = PC_WIDTH'(32'h0000_2000),
   parameter logic [31:0]            NOP_INSTR = 32'h0000_0013
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic                imem_req_valid,
   output logic [PC_WIDTH-1:0] imem_req_addr,
   input  logic                imem_req_ready,
   input  logic                imem_resp_valid,
   input  logic [31:0]         imem_resp_data,
   output logic                id_valid,
   output logic [31:0]         id_instr,
   output logic [PC_WIDTH-1:0] id_pc,
   input  logic                id_ready,
   input  logic                redirect_valid,
   input  logic [PC_WIDTH-1:0] redirect_pc
);

   typedef enum logic [1:0] {
      BOOT,
      REQ,
      WAIT,
      HOLD
   } state_t;

   state_t              state_q;
   logic [PC_WIDTH-1:0] pc_q;
   logic [PC_WIDTH-1:0] ipc_q;
   logic [31:0]         instr_q;
   logic                drop_q;
   logic [PC_WIDTH-1:0] redir_pc;
   logic [PC_WIDTH-1:0] pc_inc;
   logic                req_fire;

   assign redir_pc = {redirect_pc[PC_WIDTH-1:2], 2'b00};
   assign pc_inc   = pc_q + PC_WIDTH'(4);

   assign id_valid       = (state_q == HOLD) && !redirect_valid;
   assign id_instr       = id_valid ? instr_q : NOP_INSTR;
   assign id_pc          = ipc_q;
   assign imem_req_valid = (state_q == REQ) || (id_valid && id_ready);
   assign imem_req_addr  = pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         ipc_q   <= RESET_PC;
         instr_q <= NOP_INSTR;
         drop_q  <= 1'b0;
      end else begin
         unique case (state_q)
            BOOT: begin
               state_q <= REQ;
               if (redirect_valid) pc_q <= redir_pc;
            end
            REQ: begin
               if (req_fire) begin
                  ipc_q   <= pc_q;
                  state_q <= WAIT;
                  // request already committed: its response is wrong-path
                  if (redirect_valid) begin
                     pc_q   <= redir_pc;
                     drop_q <= 1'b1;
                  end else begin
                     pc_q <= pc_inc;
                  end
               end else if (redirect_valid) begin
                  pc_q <= redir_pc;
               end
            end
            WAIT: begin
               if (imem_resp_valid) begin
                  drop_q  <= 1'b0;
                  state_q <= REQ;
                  if (redirect_valid) begin
                     pc_q <= redir_pc;
                  end else if (!drop_q) begin
                     instr_q <= imem_resp_data;
                     state_q <= HOLD;
                  end
               end else if (redirect_valid) begin
                  pc_q   <= redir_pc;
                  drop_q <= 1'b1;
               end
            end
            HOLD: begin
               if (redirect_valid) begin
                  pc_q    <= redir_pc;
                  state_q <= REQ;
               end else if (id_ready) begin
                  if (imem_req_ready) begin
                     ipc_q   <= pc_q;
                     pc_q    <= pc_inc;
                     state_q <= WAIT;
                  end else begin
                     state_q <= REQ;
                  end
               end
            end
            default: state_q <= BOOT;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table for straight-line fetch and
// stall, hand sequences for redirects, memory stall and async reset.
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] KEY = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic        id_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   int n_chk  = 0;
   int n_pass = 0;
   int lat    = 0;

   fetch_unit dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .imem_req_valid  (imem_req_valid),
      .imem_req_addr   (imem_req_addr),
      .imem_req_ready  (imem_req_ready),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .id_valid        (id_valid),
      .id_instr        (id_instr),
      .id_pc           (id_pc),
      .id_ready        (id_ready),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc)
   );

   always #5 clk = ~clk;

   // memory: answers addr^KEY after lat extra cycles
   initial begin
      bit          pend;
      int          cnt;
      logic [31:0] paddr;
      pend            = 1'b0;
      cnt             = 0;
      paddr           = '0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            pend = 1'b0;
         end else if (imem_req_valid && imem_req_ready) begin
            pend  = 1'b1;
            paddr = imem_req_addr;
            cnt   = lat;
         end
         @(negedge clk);
         imem_resp_valid = 1'b0;
         if (pend) begin
            if (cnt == 0) begin
               imem_resp_valid = 1'b1;
               imem_resp_data  = paddr ^ KEY;
               pend            = 1'b0;
            end else begin
               cnt--;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   task automatic exp5(input string nm, input logic rqv,
                       input logic [31:0] addr, input logic iv,
                       input logic [31:0] pc, input logic [31:0] ins);
      chk({nm, ".req_valid"}, 32'(imem_req_valid), 32'(rqv));
      chk({nm, ".req_addr"}, imem_req_addr, addr);
      chk({nm, ".id_valid"}, 32'(id_valid), 32'(iv));
      chk({nm, ".id_pc"}, id_pc, pc);
      chk({nm, ".id_instr"}, id_instr, ins);
   endtask

   task automatic cyc(input logic ir, input logic rr, input logic rv,
                      input logic [31:0] rpc);
      @(negedge clk);
      id_ready       = ir;
      imem_req_ready = rr;
      redirect_valid = rv;
      redirect_pc    = rpc;
      #1;
   endtask

   typedef struct {
      logic        ir;
      logic        rr;
      logic        rqv;
      logic [31:0] addr;
      logic        iv;
      logic [31:0] pc;
      logic [31:0] ins;
   } vec_t;

   vec_t tv[13];

   initial begin
      tv[0]  = '{1, 1, 0, 32'h2000, 0, 32'h2000, NOP};
      tv[1]  = '{1, 1, 1, 32'h2000, 0, 32'h2000, NOP};
      tv[2]  = '{1, 1, 0, 32'h2004, 0, 32'h2000, NOP};
      tv[3]  = '{1, 1, 1, 32'h2004, 1, 32'h2000, 32'hA5A5_2000};
      tv[4]  = '{1, 1, 0, 32'h2008, 0, 32'h2004, NOP};
      for (int i = 5; i < 10; i++)
         tv[i] = '{0, 1, 0, 32'h2008, 1, 32'h2004, 32'hA5A5_2004};
      tv[10] = '{1, 1, 1, 32'h2008, 1, 32'h2004, 32'hA5A5_2004};
      tv[11] = '{1, 1, 0, 32'h200C, 0, 32'h2008, NOP};
      tv[12] = '{0, 1, 0, 32'h200C, 1, 32'h2008, 32'hA5A5_2008};

      rst_n          = 1'b0;
      id_ready       = 1'b0;
      imem_req_ready = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      repeat (3) @(negedge clk);
      #1;
      exp5("rst", 0, 32'h2000, 0, 32'h2000, NOP);

      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         if (i == 0) rst_n = 1'b1;
         id_ready       = tv[i].ir;
         imem_req_ready = tv[i].rr;
         redirect_valid = 1'b0;
         #1;
         exp5($sformatf("t%0d", i), tv[i].rqv, tv[i].addr, tv[i].iv,
              tv[i].pc, tv[i].ins);
      end

      // redirect while waiting on a slow response
      lat = 3;
      cyc(1, 1, 0, 0);
      exp5("a13", 1, 32'h200C, 1, 32'h2008, 32'hA5A5_2008);
      cyc(0, 1, 1, 32'h3002);
      exp5("a14", 0, 32'h2010, 0, 32'h200C, NOP);
      lat = 0;
      for (int i = 15; i < 18; i++) begin
         cyc(0, 1, 0, 0);
         exp5($sformatf("a%0d", i), 0, 32'h3000, 0, 32'h200C, NOP);
      end
      cyc(0, 1, 0, 0);
      exp5("a18", 1, 32'h3000, 0, 32'h200C, NOP);
      cyc(0, 1, 0, 0);
      exp5("a19", 0, 32'h3004, 0, 32'h3000, NOP);

      // redirect on the same edge as a request handshake
      cyc(1, 0, 0, 0);
      exp5("b20", 1, 32'h3004, 1, 32'h3000, 32'hA5A5_3000);
      cyc(0, 1, 1, 32'h4000);
      exp5("b21", 1, 32'h3004, 0, 32'h3000, NOP);
      cyc(0, 1, 0, 0);
      exp5("b22", 0, 32'h4000, 0, 32'h3004, NOP);
      cyc(0, 1, 0, 0);
      exp5("b23", 1, 32'h4000, 0, 32'h3004, NOP);
      cyc(0, 1, 0, 0);
      exp5("b24", 0, 32'h4004, 0, 32'h4000, NOP);
      cyc(0, 1, 0, 0);
      exp5("b25", 1'b0, 32'h4004, 1, 32'h4000, 32'hA5A5_4000);

      // redirect in HOLD beats a consuming id_ready
      cyc(1, 1, 1, 32'h5007);
      exp5("h26", 0, 32'h4004, 0, 32'h4000, NOP);

      // memory not ready for 4 cycles
      for (int i = 27; i < 31; i++) begin
         cyc(0, 0, 0, 0);
         exp5($sformatf("s%0d", i), 1, 32'h5004, 0, 32'h4000, NOP);
      end
      cyc(0, 1, 0, 0);
      exp5("s31", 1, 32'h5004, 0, 32'h4000, NOP);
      cyc(0, 1, 0, 0);
      exp5("s32", 0, 32'h5008, 0, 32'h5004, NOP);
      cyc(0, 1, 0, 0);
      exp5("s33", 0, 32'h5008, 1, 32'h5004, 32'hA5A5_5004);

      // async reset while holding
      #2;
      rst_n = 1'b0;
      #1;
      exp5("r_async", 0, 32'h2000, 0, 32'h2000, NOP);
      repeat (2) @(negedge clk);
      rst_n          = 1'b1;
      id_ready       = 1'b1;
      imem_req_ready = 1'b1;
      #1;
      exp5("r0", 0, 32'h2000, 0, 32'h2000, NOP);
      cyc(1, 1, 0, 0);
      exp5("r1", 1, 32'h2000, 0, 32'h2000, NOP);
      cyc(1, 1, 0, 0);
      exp5("r2", 0, 32'h2004, 0, 32'h2000, NOP);
      cyc(1, 1, 0, 0);
      exp5("r3", 1, 32'h2004, 1, 32'h2000, 32'hA5A5_2000);

      // redirect coincident with response: nothing left to drop
      cyc(0, 1, 1, 32'h6000);
      exp5("w4", 0, 32'h2008, 0, 32'h2004, NOP);
      cyc(0, 1, 0, 0);
      exp5("w5", 1, 32'h6000, 0, 32'h2004, NOP);
      cyc(0, 1, 0, 0);
      exp5("w6", 0, 32'h6004, 0, 32'h6000, NOP);
      cyc(0, 1, 0, 0);
      exp5("w7", 0, 32'h6004, 1, 32'h6000, 32'hA5A5_6000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the control decoder.
- Owns the PC register, issues one instruction-memory request at a time over a valid/ready handshake, and buffers the returned word.
- Presents {instr, pc, valid} to the decode stage.
- Handles decode back-pressure and control-flow redirects; wrong-path responses are squashed and the NOP 0x00000013 is driven whenever no valid instruction is presented.

Parameters:
- PC_WIDTH, 32, width of all PC/address signals.
- RESET_PC, 32'h0000_2000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, word driven on id_instr when id_valid=0 (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- imem_req_valid  out  1  request valid.
- imem_req_addr  out  PC_WIDTH  request address, word aligned.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_resp_valid  in  1  response data valid, at least one cycle after acceptance.
- imem_resp_data  in  32  instruction word.
- id_valid  out  1  id_instr/id_pc hold a live instruction.
- id_instr  out  32  instruction to the decoder.
- id_pc  out  PC_WIDTH  address of id_instr.
- id_ready  in  1  decode consumes the instruction this cycle; low means stall.
- redirect_valid  in  1  branch/jump/trap redirect.
- redirect_pc  in  PC_WIDTH  redirect target.

Behaviour:
- Reset: clock is clk; reset is asynchronous and active-low (rst_n).
  - On rst_n=0: state=BOOT, pc_q=RESET_PC, drop_q=0, instr_q=NOP_INSTR, ipc_q=RESET_PC.
  - Outputs during reset: imem_req_valid=0, id_valid=0, id_instr=NOP_INSTR, id_pc=RESET_PC.
- States: BOOT, REQ, WAIT, HOLD.
- BOOT: no request. Go to REQ next cycle; a redirect in this cycle loads pc_q.
- REQ: imem_req_valid=1, imem_req_addr=pc_q.
  - On imem_req_ready: ipc_q<=pc_q, pc_q<=pc_q+4, go to WAIT.
- WAIT: imem_req_valid=0.
  - On imem_resp_valid with drop_q=1: discard the data, drop_q<=0, go to REQ.
  - On imem_resp_valid with drop_q=0: instr_q<=imem_resp_data, go to HOLD.
- HOLD: id_valid=1, id_instr=instr_q, id_pc=ipc_q.
  - id_ready=0: hold everything; outputs stay stable for any number of cycles.
  - id_ready=1: the instruction is consumed. imem_req_valid=1 in the same cycle with imem_req_addr=pc_q.
    - If imem_req_ready: update ipc_q/pc_q as in REQ and go to WAIT.
    - Otherwise go to REQ.
- Steady-state throughput: one instruction per 2 cycles with zero-wait memory.
- id_valid = (state==HOLD) && !redirect_valid. id_instr=NOP_INSTR whenever id_valid=0. id_pc=ipc_q always.
- Redirect has priority over every other event in the same cycle:
  - pc_q <= {redirect_pc[PC_WIDTH-1:2],2'b00}; low two bits are forced to zero.
  - In HOLD: the held instruction is discarded even if id_ready=1. Go to REQ; no request is issued this cycle.
  - In WAIT without imem_resp_valid: drop_q<=1, stay in WAIT.
  - In WAIT with imem_resp_valid the same cycle: discard the data, go to REQ, drop_q stays 0.
  - In REQ with imem_req_ready the same cycle: the request is already committed. Go to WAIT with drop_q<=1; pc_q takes the redirect target, not +4.
  - Multiple redirects while drop_q=1: the last target wins; drop_q stays 1, and only one response is dropped.
- imem_resp_valid outside WAIT is a protocol violation: ignored, with no state change.
- pc_q+4 wraps modulo 2^PC_WIDTH; there is no overflow flag.
- Async reset mid-transaction returns to BOOT. Any response still in flight from the old request arrives in BOOT/REQ and is ignored; the memory side must also be reset.
- At most one request outstanding at any time.

Test Plan:
- Reset release, zero-wait memory returning addr^0xA5A5_0000, id_ready=1:
  - Requests at 0x2000, 0x2004, 0x2008.
  - id_pc/id_instr pairs match; id_valid pulses every 2nd cycle.
  - First id_valid on cycle 3 after rst_n rises.
- id_ready=0 for 5 cycles while holding pc 0x2004:
  - id_instr/id_pc stay constant and imem_req_valid=0.
  - After release, the next request is 0x2008.
- Redirect to 0x3002 while in WAIT, response arriving 3 cycles later:
  - The response is dropped and id_valid stays 0.
  - The next request is 0x3000, and the id stage sees pc 0x3000.
- Redirect coincident with REQ handshake (imem_req_ready=1):
  - The old response is dropped; the next request is the redirect target.
  - No wrong-path id_valid appears.
- imem_req_ready held 0 for 4 cycles: imem_req_valid and imem_req_addr stay stable; no PC advance.
- rst_n asserted while in HOLD:
  - id_valid=0 and id_instr=0x00000013 immediately (asynchronous).
  - After release, fetch restarts at 0x2000.
